pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline stall/flush controller for the in-order CPU. It replaces the fixed all-zero
//  stall generator and sits beside the datapath, driving the per-stage hold vector, the redirect flush
//  and new_pc. Adds load-use bubble timing, registered redirect, and a stall watchdog.
// PARAMETERS
//  NUM_STAGES   6   stall vector width; bit 0 = PC, bit k = pipeline register k (matches StallBus)
//  PC_W         32  width of flush_pc/new_pc
//  LOAD_STAGE   2   highest stage held by a load-use hazard (ID)
//  LOAD_BUBBLES 1   stall cycles per load_use pulse, 1..7
//  TIMEOUT      255 continuous-stall cycles before stall_timeout sets, 1..65535
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           synchronous reset, active-low
//  stallreq      in   NUM_STAGES  level requests; bit k=1: stage k needs to hold this cycle
//  load_use      in   1           one-cycle pulse from ID: load-use hazard detected
//  flush_req     in   1           redirect request (exception/eret/mispredict), one-cycle pulse
//  flush_pc      in   PC_W        redirect target, sampled with flush_req
//  timeout_clr   in   1           clears sticky stall_timeout
//  stall         out  NUM_STAGES  hold vector; bit j=1: stage j holds
//  flush         out  1           one-cycle flush of all pipeline registers
//  new_pc        out  PC_W        redirect target, valid while flush=1
//  stall_timeout out  1           sticky watchdog flag
// BEHAVIOUR
//  Reset (rst=0 at edge): stall=0, flush=0, new_pc=0, stall_timeout=0, load_cnt=0, stall_cnt=0, state=RUN.
//  Effective request eff[k] = stallreq[k] | (k==LOAD_STAGE & load_active).
//  load_active = load_use | (load_cnt!=0); combinational, so the pulse cycle itself stalls.
//  Stall vector (combinational): h = highest k with eff[k]=1; stall[j]=1 for all j<=h, else 0.
//   No request -> stall=0. A bubble enters stage h+1 by pipeline-register convention, not here.
//  load_cnt (3 bit): on load_use load_cnt<=LOAD_BUBBLES-1; else if nonzero decrement; total stall
//   cycles per pulse = LOAD_BUBBLES. load_use while load_cnt!=0 reloads (no accumulation).
//  FSM states RUN, FLUSH:
//   RUN  : flush_req=1 -> FLUSH, capture new_pc<=flush_pc, flush<=1.
//   FLUSH: flush=1 this cycle; stall forced to 0 regardless of requests; load_cnt<=0; load_use ignored.
//          flush_req=1 again -> stay FLUSH, new_pc<=flush_pc (latest target wins); else -> RUN, flush<=0.
//  Latency: flush_req at edge n -> flush=1, new_pc valid in cycle n+1; exactly one cycle per request.
//  new_pc holds its last value after flush drops.
//  Watchdog: stall_cnt (16 bit, saturating at TIMEOUT) increments each cycle stall[0]=1, clears to 0
//   when stall[0]=0. stall_cnt reaching TIMEOUT sets stall_timeout; stays set until timeout_clr=1 or reset.
//   timeout_clr and set in same cycle: set wins.
//  Simultaneous flush_req and load_use in RUN: flush taken; load_cnt still loads but is cleared in FLUSH.
//  Reset mid-flush or mid-bubble: all state returns to reset values at the next edge, no residual flush.
// TESTING
//  1 Reset: rst=0 for 3 cycles with stallreq=6'h3F, flush_req=1 -> flush=0, new_pc=0, stall_timeout=0
//    after the first edge; stall tracks stallreq combinationally (6'h3F).
//  2 Vector: stallreq=6'b001000 -> stall=6'b001111; stallreq=6'b000101 -> 6'b000111; 0 -> 0.
//  3 Load bubbles (LOAD_BUBBLES=2): load_use pulse at cycle n -> stall=6'b000111 in cycles n and n+1,
//    0 at n+2; second pulse at n+1 extends the stall through n+2.
//  4 Flush: flush_req=1, flush_pc=32'hBFC00380 at edge n -> cycle n+1 flush=1, new_pc=BFC00380,
//    stall=0 despite stallreq=6'h0F; back-to-back flush_req with 32'h00400000 -> second flush cycle
//    with new_pc=00400000.
//  5 Watchdog (TIMEOUT=4): stallreq[3]=1 held 4 cycles -> stall_timeout=1 and stays set after release;
//    timeout_clr pulse -> 0; 3-cycle stall -> stays 0.
//  6 Mid-op reset: assert rst=0 during FLUSH and during a 3-cycle load bubble -> next cycle flush=0,
//    stall=stallreq only.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: builds the per-stage hold vector from level requests and
// load-use bubbles, issues a registered one-cycle redirect flush, and watches for stuck stalls.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES   = 6,
   parameter int PC_W         = 32,
   parameter int LOAD_STAGE   = 2,
   parameter int LOAD_BUBBLES = 1,
   parameter int TIMEOUT      = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_STAGES-1:0] stallreq_i,
   input  logic                  load_use_i,
   input  logic                  flush_req_i,
   input  logic [PC_W-1:0]       flush_pc_i,
   input  logic                  timeout_clr_i,
   output logic [NUM_STAGES-1:0] stall_o,
   output logic                  flush_o,
   output logic [PC_W-1:0]       new_pc_o,
   output logic                  stall_timeout_o
);

   // state | meaning
   // RUN   | normal operation, stall vector follows requests
   // FLUSH | redirect cycle: flush asserted, all holds and load bubbles suppressed
   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [2:0]  LB_LAST = 3'(LOAD_BUBBLES - 1);
   localparam logic [15:0] TO_CNT  = 16'(TIMEOUT);

   state_t                state_q, state_d;
   logic [PC_W-1:0]       new_pc_q, new_pc_d;
   logic [2:0]            load_cnt_q, load_cnt_d;
   logic [15:0]           stall_cnt_q, stall_cnt_d;
   logic                  timeout_q, timeout_d;
   logic                  load_active;
   logic [NUM_STAGES-1:0] eff;
   logic [NUM_STAGES-1:0] stall_vec;
   logic                  acc;

   assign load_active = (state_q == RUN) && (load_use_i || (load_cnt_q != 3'd0));

   // Thermometer fill: every stage at or below the highest requester holds.
   always_comb begin
      eff       = stallreq_i;
      stall_vec = '0;
      acc       = 1'b0;
      if (load_active) eff[LOAD_STAGE] = 1'b1;
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
         acc          = acc | eff[j];
         stall_vec[j] = acc;
      end
      if (state_q == FLUSH) stall_vec = '0;
   end

   always_comb begin
      state_d    = state_q;
      new_pc_d   = new_pc_q;
      load_cnt_d = load_cnt_q;
      case (state_q)
         RUN: begin
            if (load_use_i)               load_cnt_d = LB_LAST;
            else if (load_cnt_q != 3'd0)  load_cnt_d = load_cnt_q - 3'd1;
            if (flush_req_i) begin
               state_d  = FLUSH;
               new_pc_d = flush_pc_i;
            end
         end
         FLUSH: begin
            load_cnt_d = 3'd0;
            if (flush_req_i) new_pc_d = flush_pc_i;
            else             state_d  = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Saturating watchdog; a new set outranks a simultaneous clear.
   always_comb begin
      stall_cnt_d = 16'd0;
      timeout_d   = timeout_q;
      if (stall_vec[0]) stall_cnt_d = (stall_cnt_q == TO_CNT) ? stall_cnt_q : stall_cnt_q + 16'd1;
      if (timeout_clr_i) timeout_d = 1'b0;
      if (stall_vec[0] && (stall_cnt_d == TO_CNT)) timeout_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= RUN;
         new_pc_q    <= '0;
         load_cnt_q  <= 3'd0;
         stall_cnt_q <= 16'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         new_pc_q    <= new_pc_d;
         load_cnt_q  <= load_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign stall_o         = stall_vec;
   assign flush_o         = (state_q == FLUSH);
   assign new_pc_o        = new_pc_q;
   assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] new_pc;
      logic        timeout;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  stallreq = 6'h3F;
   logic        load_use = 1'b0;
   logic        flush_req = 1'b1;
   logic [31:0] flush_pc = 32'h1234_5678;
   logic        timeout_clr = 1'b0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .NUM_STAGES(6), .PC_W(32), .LOAD_STAGE(2), .LOAD_BUBBLES(2), .TIMEOUT(4)
   ) dut (
      .clk_i(clk), .rst_i(rst), .stallreq_i(stallreq), .load_use_i(load_use),
      .flush_req_i(flush_req), .flush_pc_i(flush_pc), .timeout_clr_i(timeout_clr),
      .stall_o(stall), .flush_o(flush), .new_pc_o(new_pc), .stall_timeout_o(stall_timeout)
   );

   // One cycle: drive inputs just after the edge and queue what the outputs must show this cycle.
   task automatic cyc(input string nm, input logic r, input logic [5:0] sr, input logic lu,
                      input logic fr, input logic [31:0] pc, input logic clr,
                      input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                      input logic e_to);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; stallreq = sr; load_use = lu; flush_req = fr; flush_pc = pc; timeout_clr = clr;
      e.stall = e_stall; e.flush = e_flush; e.new_pc = e_pc; e.timeout = e_to;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_cmp++;
         if (stall !== e.stall || flush !== e.flush || new_pc !== e.new_pc ||
             stall_timeout !== e.timeout) begin
            n_bad++;
            $display("FAIL %s: got stall=%b flush=%b new_pc=%h to=%b, want stall=%b flush=%b new_pc=%h to=%b",
                     nm, stall, flush, new_pc, stall_timeout, e.stall, e.flush, e.new_pc, e.timeout);
         end
      end
   end

   initial begin
      //   name         rst sr         lu fr pc            clr  stall      fl pc            to
      cyc("reset0",     0, 6'h3F,     0, 1, 32'h12345678, 0,  6'h3F,     0, 32'h0,        0);
      cyc("reset1",     0, 6'h3F,     0, 1, 32'h12345678, 0,  6'h3F,     0, 32'h0,        0);
      cyc("reset2",     0, 6'h3F,     0, 1, 32'h12345678, 0,  6'h3F,     0, 32'h0,        0);
      cyc("vec_s3",     1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h0,        0);
      cyc("vec_s2s0",   1, 6'b000101, 0, 0, 32'h0,        0,  6'b000111, 0, 32'h0,        0);
      cyc("vec_none",   1, 6'b000000, 0, 0, 32'h0,        0,  6'b000000, 0, 32'h0,        0);
      cyc("ld_pulse",   1, 6'b000000, 1, 0, 32'h0,        0,  6'b000111, 0, 32'h0,        0);
      cyc("ld_bub2",    1, 6'b000000, 0, 0, 32'h0,        0,  6'b000111, 0, 32'h0,        0);
      cyc("ld_done",    1, 6'b000000, 0, 0, 32'h0,        0,  6'b000000, 0, 32'h0,        0);
      cyc("ld2_p1",     1, 6'b000000, 1, 0, 32'h0,        0,  6'b000111, 0, 32'h0,        0);
      cyc("ld2_p2",     1, 6'b000000, 1, 0, 32'h0,        0,  6'b000111, 0, 32'h0,        0);
      cyc("ld2_ext",    1, 6'b000000, 0, 0, 32'h0,        0,  6'b000111, 0, 32'h0,        0);
      cyc("ld2_done",   1, 6'b000000, 0, 0, 32'h0,        0,  6'b000000, 0, 32'h0,        0);
      cyc("fl_req",     1, 6'h0F,     0, 1, 32'hBFC00380, 0,  6'b001111, 0, 32'h0,        0);
      cyc("fl_first",   1, 6'h0F,     0, 1, 32'h00400000, 0,  6'b000000, 1, 32'hBFC00380, 0);
      cyc("fl_second",  1, 6'h0F,     1, 0, 32'h0,        0,  6'b000000, 1, 32'h00400000, 0);
      cyc("fl_end",     1, 6'h00,     0, 0, 32'h0,        0,  6'b000000, 0, 32'h00400000, 0);
      cyc("fl_ld_both", 1, 6'h00,     1, 1, 32'h00001000, 0,  6'b000111, 0, 32'h00400000, 0);
      cyc("fl_ld_fl",   1, 6'h00,     0, 0, 32'h0,        0,  6'b000000, 1, 32'h00001000, 0);
      cyc("fl_ld_clr",  1, 6'h00,     0, 0, 32'h0,        0,  6'b000000, 0, 32'h00001000, 0);
      cyc("wd_s1",      1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wd_s2",      1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wd_s3",      1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wd_s4",      1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wd_set",     1, 6'b000000, 0, 0, 32'h0,        0,  6'b000000, 0, 32'h00001000, 1);
      cyc("wd_sticky",  1, 6'b000000, 0, 0, 32'h0,        1,  6'b000000, 0, 32'h00001000, 1);
      cyc("wd_clr",     1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wd3_s2",     1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wd3_s3",     1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wd3_rel",    1, 6'b000000, 0, 0, 32'h0,        0,  6'b000000, 0, 32'h00001000, 0);
      cyc("wd3_quiet",  1, 6'b000000, 0, 0, 32'h0,        0,  6'b000000, 0, 32'h00001000, 0);
      cyc("wds_s1",     1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wds_s2",     1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wds_s3",     1, 6'b001000, 0, 0, 32'h0,        0,  6'b001111, 0, 32'h00001000, 0);
      cyc("wds_s4clr",  1, 6'b001000, 0, 0, 32'h0,        1,  6'b001111, 0, 32'h00001000, 0);
      cyc("wds_setwin", 1, 6'b000000, 0, 0, 32'h0,        1,  6'b000000, 0, 32'h00001000, 1);
      cyc("wds_clr",    1, 6'b000000, 0, 0, 32'h0,        0,  6'b000000, 0, 32'h00001000, 0);
      cyc("mr_flreq",   1, 6'b000000, 0, 1, 32'hABCD0000, 0,  6'b000000, 0, 32'h00001000, 0);
      cyc("mr_inflush", 0, 6'b000010, 0, 0, 32'h0,        0,  6'b000000, 1, 32'hABCD0000, 0);
      cyc("mr_fl_rst",  1, 6'b000010, 0, 0, 32'h0,        0,  6'b000011, 0, 32'h0,        0);
      cyc("mr_ld1",     1, 6'b000000, 1, 0, 32'h0,        0,  6'b000111, 0, 32'h0,        0);
      cyc("mr_ld2",     1, 6'b000000, 1, 0, 32'h0,        0,  6'b000111, 0, 32'h0,        0);
      cyc("mr_ld3rst",  0, 6'b000000, 0, 0, 32'h0,        0,  6'b000111, 0, 32'h0,        0);
      cyc("mr_ld_rst",  1, 6'b000001, 0, 0, 32'h0,        0,  6'b000001, 0, 32'h0,        0);
      cyc("mr_idle",    1, 6'b000000, 0, 0, 32'h0,        0,  6'b000000, 0, 32'h0,        0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
